// File: rtl/soma_produto_display.sv
// soma_produto_display: sequential add/multiply with double-dabble BCD conversion and a scanned seven-segment display
module soma_produto_display #(
  parameter int WIDTH    = 4,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic [6:0]           seg,
  output logic [DIGITS-1:0]    an
);
  localparam int RW = 2*WIDTH;
  localparam int CW = $clog2(RW);
  localparam int BW = 4*DIGITS;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] MUL_LAST  = CW'(WIDTH-1);
  localparam logic [CW-1:0] CONV_LAST = CW'(RW-1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV-1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS-1);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
  typedef enum logic [1:0] {IDLE, CALC, CONV} state_t;
  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [RW-1:0]     acc_q, acc_d;
  logic [RW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [RW-1:0]     res_q, res_d;
  logic [BW-1:0]     disp_q, disp_d;
  logic              done_q, done_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [DIGITS-1:0] blank;
  logic [RW-1:0]     sum_nxt;
  logic              nz, wrap;
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    res_d    = res_q;
    disp_d   = disp_q;
    done_d   = 1'b0;
    bcd_adj  = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    sum_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      IDLE: if (start) begin
        state_d  = CALC;
        mode_d   = mode;
        acc_d    = '0;
        mcand_d  = RW'(a);
        mplier_d = b;
        cnt_d    = '0;
      end
      CALC: begin
        acc_d    = mode_q ? sum_nxt : mcand_q + RW'(mplier_q);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (!mode_q || cnt_q == MUL_LAST) begin
          state_d = CONV;
          bin_d   = acc_d;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CONV_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          res_d   = acc_q;
          disp_d  = bcd_d;
        end
      end
      default: state_d = IDLE;
    endcase
    wrap   = scnt_q == SCAN_LAST;
    scnt_d = wrap ? '0 : scnt_q + SW'(1);
    idx_d  = wrap ? (idx_q == IDX_LAST ? '0 : idx_q + IW'(1)) : idx_q;
    nz     = 1'b0;
    blank  = '0;
    for (int i = DIGITS-1; i > 0; i--) begin
      nz       = nz | (disp_d[4*i +: 4] != 4'd0);
      blank[i] = ~nz;
    end
    seg_d = blank[idx_d] ? 7'b1111111 : SEG_LUT[disp_d[4*idx_d +: 4]];
    an_d  = ~(DIGITS'(1) << idx_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      res_q    <= '0;
      disp_q   <= '0;
      done_q   <= 1'b0;
      scnt_q   <= '0;
      idx_q    <= '0;
      seg_q    <= 7'b0000001;
      an_q     <= ~DIGITS'(1);
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      res_q    <= res_d;
      disp_q   <= disp_d;
      done_q   <= done_d;
      scnt_q   <= scnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end
  assign busy   = state_q != IDLE;
  assign done   = done_q;
  assign result = res_q;
  assign seg    = seg_q;
  assign an     = an_q;
endmodule

// File: tb/tb_soma_produto_display.sv
// tb_soma_produto_display: randomized and directed check of soma_produto_display against a behavioural model
module tb_soma_produto_display;
  localparam int W = 4;
  localparam int D = 3;
  localparam int SD = 4;
  logic clk = 1'b0;
  logic rst, start, mode;
  logic [W-1:0] a, b;
  logic busy, done;
  logic [2*W-1:0] result;
  logic [6:0] seg;
  logic [D-1:0] an;
  int n_chk = 0;
  int n_err = 0;
  int cd = 0;
  int pend = 0;
  int m_res = 0;
  int cyc = 0;
  bit m_done = 0;
  bit valid = 0;
  logic [6:0] lut [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  soma_produto_display #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .seg(seg), .an(an));
  always #5 clk = ~clk;
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic [6:0] exp_seg(int v, int i);
    int p = 1;
    for (int k = 0; k < i; k++) p *= 10;
    if (i > 0 && v < p) return 7'b1111111;
    return lut[(v / p) % 10];
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      cd = 0; m_done = 0; m_res = 0; cyc = 0; valid = 1;
    end else begin
      cyc++;
      if (cd > 0) begin
        cd--;
        m_done = (cd == 0);
        if (m_done) m_res = pend;
      end else begin
        m_done = 0;
        if (start) begin
          cd = mode ? 3*W : 1 + 2*W;
          pend = mode ? int'(a) * int'(b) : int'(a) + int'(b);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (valid) begin
      int idx;
      idx = (cyc / SD) % D;
      chk("busy", int'(busy), int'(cd > 0));
      chk("done", int'(done), int'(m_done));
      chk("result", int'(result), m_res);
      chk("an", int'(an), int'(3'(~(3'b001 << idx))));
      chk("seg", int'(seg), int'(exp_seg(m_res, idx)));
    end
  end
  task automatic run_op(logic m, logic [W-1:0] x, logic [W-1:0] y, int r, int lat);
    int k = 0;
    mode = m; a = x; b = y; start = 1;
    @(posedge clk); #1 start = 0;
    while (k < 60) begin
      @(posedge clk); #1;
      k++;
      if (done) break;
    end
    chk("latency", k, lat);
    chk("op_result", int'(result), r);
  endtask
  task automatic check_digit(int i, logic [6:0] s);
    int k = 0;
    while (an != 3'(~(3'b001 << i)) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("digit_found", int'(k < 20), 1);
    chk($sformatf("digit%0d_seg", i), int'(seg), int'(s));
  endtask
  initial begin
    int nd;
    logic [2:0] pat;
    rst = 1; start = 0; mode = 0; a = 0; b = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_an", int'(an), 6);
    chk("rst_seg", int'(seg), 1);
    for (int i = 0; i <= 12; i++) begin
      pat = i < 4 ? 3'b110 : i < 8 ? 3'b101 : i < 12 ? 3'b011 : 3'b110;
      chk($sformatf("scan_an%0d", i), int'(an), int'(pat));
      @(posedge clk); #1;
    end
    check_digit(1, 7'b1111111);
    check_digit(2, 7'b1111111);
    run_op(0, 3, 2, 5, 9);
    check_digit(0, 7'b0100100);
    check_digit(1, 7'b1111111);
    check_digit(2, 7'b1111111);
    run_op(1, 15, 15, 225, 12);
    check_digit(2, 7'b0010010);
    check_digit(1, 7'b0010010);
    check_digit(0, 7'b0100100);
    mode = 1; a = 7; b = 3; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #1 mode = 0; a = 1; b = 1; start = 1;
    @(posedge clk); #1 start = 0;
    nd = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("ignored_done_count", nd, 1);
    chk("ignored_result", int'(result), 21);
    mode = 1; a = 15; b = 15; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_done_count", nd, 0);
    chk("abort_result", int'(result), 0);
    check_digit(0, 7'b0000001);
    check_digit(1, 7'b1111111);
    run_op(0, 4, 4, 8, 9);
    run_op(1, 9, 9, 81, 12);
    run_op(1, 0, 13, 0, 12);
    run_op(0, 15, 15, 30, 9);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = ($urandom % 300) == 0;
      start = ($urandom % 3) == 0;
      mode = 1'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
    end
    @(negedge clk);
    rst = 0; start = 0;
    repeat (30) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
